// File: rtl/issuer_pkg.sv
// Shared definitions for the instruction issuer: FSM state encoding, the HALT word and the
// instruction field layout common with the compute core.
package issuer_pkg;

    localparam int ADDRESS_WIDTH_DEF     = 16;
    localparam int INSTRUCTION_WIDTH_DEF = 15;
    localparam int COUNT_WIDTH_DEF       = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_MEM  = 3'd2,
        DECODE    = 3'd3,
        ISSUE     = 3'd4,
        WAIT_BUSY = 3'd5,
        HALTED    = 3'd6
    } issuer_state_e;

    // Non-ALU, opcode 0: the all-zero word stops the issuer.
    localparam logic [INSTRUCTION_WIDTH_DEF-1:0] HALT_WORD = '0;

    localparam int ALU_BIT  = 0;
    localparam int SEL_LSB  = 1;
    localparam int SEL_MSB  = 4;
    localparam int COND_LSB = 5;
    localparam int COND_MSB = 8;
    localparam int A_LSB    = 9;
    localparam int A_MSB    = 10;
    localparam int B_LSB    = 11;
    localparam int B_MSB    = 12;
    localparam int DEST_LSB = 13;
    localparam int DEST_MSB = 14;

endpackage

// File: rtl/instr_issuer.sv
// Instruction fetch/issue front end: fetches from synchronous instruction RAM and hands one word
// at a time to the core. Define INSTR_ISSUER_STEP_EN to add a single-step input.
module instr_issuer
    import issuer_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = ADDRESS_WIDTH_DEF,
    parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
    parameter int COUNT_WIDTH       = COUNT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDRESS_WIDTH-1:0]     start_pc,
    input  logic                         stop,
    output logic [ADDRESS_WIDTH-1:0]     imem_addr,
    output logic                         imem_rden,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         cpen,
    input  logic                         core_busy,
`ifdef INSTR_ISSUER_STEP_EN
    input  logic                         step,
`endif
    output logic [ADDRESS_WIDTH-1:0]     pc,
    output logic                         running,
    output logic                         halted,
    output logic [COUNT_WIDTH-1:0]       issue_count
);

    issuer_state_e                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic [COUNT_WIDTH-1:0]       count_q, count_d;
    logic                         stop_req_q, stop_req_d;
    logic                         busy_first_q, busy_first_d;
    logic                         stop_pend;
    logic                         busy_clear;
    logic                         step_ok;

`ifdef INSTR_ISSUER_STEP_EN
    logic step_seen_q, step_seen_d;
    assign step_ok = step_seen_q | step;
`else
    assign step_ok = 1'b1;
`endif

    assign stop_pend  = stop_req_q | stop;
    assign busy_clear = !busy_first_q && !core_busy;

    // NOTE: every variable gets its default before the case, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        instr_d      = instr_q;
        count_d      = count_q;
        stop_req_d   = stop_pend;
        busy_first_d = 1'b0;
`ifdef INSTR_ISSUER_STEP_EN
        step_seen_d  = (state_q == WAIT_BUSY) ? step_ok : 1'b0;
`endif
        case (state_q)
            IDLE, HALTED: begin
                stop_req_d = 1'b0;
                if (start) begin
                    pc_d    = start_pc;
                    count_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (stop_pend) begin
                    stop_req_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                ir_d    = imem_rdata;
                state_d = DECODE;
            end
            DECODE: begin
                if (ir_q == INSTRUCTION_WIDTH'(HALT_WORD)) begin
                    state_d = HALTED;
                end else begin
                    // Load the word now so it is already stable while cpen is high.
                    instr_d = ir_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pc_d         = pc_q + 1'b1;
                count_d      = count_q + 1'b1;
                busy_first_d = 1'b1;
                state_d      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Stop bypasses the single-step wait.
                if (busy_clear && stop_pend) begin
                    stop_req_d = 1'b0;
                    state_d    = IDLE;
                end else if (busy_clear && step_ok) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            instr_q      <= '0;
            count_q      <= '0;
            stop_req_q   <= 1'b0;
            busy_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            instr_q      <= instr_d;
            count_q      <= count_d;
            stop_req_q   <= stop_req_d;
            busy_first_q <= busy_first_d;
        end
    end

`ifdef INSTR_ISSUER_STEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_seen_q <= 1'b0;
        end else begin
            step_seen_q <= step_seen_d;
        end
    end
`endif

    assign imem_addr   = pc_q;
    assign imem_rden   = (state_q == FETCH) && !stop_pend;
    assign cpen        = (state_q == ISSUE);
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign running     = (state_q != IDLE) && (state_q != HALTED);
    assign halted      = (state_q == HALTED);
    assign issue_count = count_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboard bench for instr_issuer: expected fetch addresses and issued words are queued by the
// stimulus, and a monitor pops and compares them whenever the DUT fetches or strobes cpen.
module tb_instr_issuer;

    localparam int AW = 16;
    localparam int IW = 15;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic          stop = 1'b0;
    logic [AW-1:0] imem_addr;
    logic          imem_rden;
    logic [IW-1:0] imem_rdata = '0;
    logic [IW-1:0] instruction;
    logic          cpen;
    logic          core_busy = 1'b0;
    logic [AW-1:0] pc;
    logic          running;
    logic          halted;
    logic [CW-1:0] issue_count;
`ifdef INSTR_ISSUER_STEP_EN
    logic          step = 1'b1;
`endif

    instr_issuer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .stop        (stop),
        .imem_addr   (imem_addr),
        .imem_rden   (imem_rden),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .cpen        (cpen),
        .core_busy   (core_busy),
`ifdef INSTR_ISSUER_STEP_EN
        .step        (step),
`endif
        .pc          (pc),
        .running     (running),
        .halted      (halted),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] mem [0:65535];
    always @(posedge clk) if (imem_rden) imem_rdata <= mem[imem_addr];

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] exp_instr_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int gap_q[$];
    int cycle = 0;
    int last_cpen_cycle = -1;
    logic prev_cpen = 1'b0;
    int busy_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Core model: busy rises just after the cpen edge and holds for busy_len cycles.
    initial forever begin
        @(posedge clk);
        #2;
        if (cpen && busy_len > 0) begin
            core_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #2;
            core_busy = 1'b0;
        end
    end

    // Monitor: compares every fetch and every issue against the queued expectations.
    initial forever begin
        @(negedge clk);
        cycle++;
        if (rst_n) begin
            if (imem_rden) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_fetch", {48'd0, imem_addr}, 64'hFFFF_FFFF);
                end else begin
                    check("fetch_addr", {48'd0, imem_addr}, {48'd0, exp_addr_q.pop_front()});
                end
                check("fetch_while_busy", {63'd0, core_busy}, 64'd0);
            end
            if (cpen) begin
                if (exp_instr_q.size() == 0) begin
                    check("unexpected_cpen", {49'd0, instruction}, 64'hFFFF_FFFF);
                end else begin
                    check("instruction", {49'd0, instruction}, {49'd0, exp_instr_q.pop_front()});
                end
                check("cpen_width", {63'd0, prev_cpen}, 64'd0);
                if (last_cpen_cycle >= 0) gap_q.push_back(cycle - last_cpen_cycle);
                last_cpen_cycle = cycle;
            end
        end
        prev_cpen = rst_n ? cpen : 1'b0;
    end

    task automatic do_start(input logic [AW-1:0] addr);
        @(negedge clk);
        last_cpen_cycle = -1;
        gap_q.delete();
        start_pc = addr;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!halted) check("halt_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_cpen(input int budget);
        int n = 0;
        @(negedge clk);
        while (!cpen && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!cpen) check("cpen_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},          {48'd0, pc},          64'd0);
        check({tag, "_imem_addr"},   {48'd0, imem_addr},   64'd0);
        check({tag, "_imem_rden"},   {63'd0, imem_rden},   64'd0);
        check({tag, "_instruction"}, {49'd0, instruction}, 64'd0);
        check({tag, "_cpen"},        {63'd0, cpen},        64'd0);
        check({tag, "_issue_count"}, {32'd0, issue_count}, 64'd0);
        check({tag, "_running"},     {63'd0, running},     64'd0);
        check({tag, "_halted"},      {63'd0, halted},      64'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;

        // Reset state
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: two issues then HALT, busy never high
        mem[16'h0010] = 15'h0003;
        mem[16'h0011] = 15'h2A05;
        mem[16'h0012] = 15'h0000;
        busy_len = 0;
        exp_addr_q  = '{16'h0010, 16'h0011, 16'h0012};
        exp_instr_q = '{15'h0003, 15'h2A05};
        do_start(16'h0010);
        wait_halt(100);
        check("t1_halted",      {63'd0, halted},      64'd1);
        check("t1_running",     {63'd0, running},     64'd0);
        check("t1_pc",          {48'd0, pc},          64'h0012);
        check("t1_issue_count", {32'd0, issue_count}, 64'd2);
        check("t1_instruction", {49'd0, instruction}, 64'h2A05);
        check("t1_gap_count",   64'(gap_q.size()),    64'd1);
        if (gap_q.size() > 0) check("t1_min_gap", 64'(gap_q[0]), 64'd6);

        // 2: busy high 5 cycles after each cpen
        mem[16'h0020] = 15'h0102;
        mem[16'h0021] = 15'h1234;
        mem[16'h0022] = 15'h0000;
        busy_len = 5;
        exp_addr_q  = '{16'h0020, 16'h0021, 16'h0022};
        exp_instr_q = '{15'h0102, 15'h1234};
        do_start(16'h0020);
        wait_halt(200);
        check("t2_pc",          {48'd0, pc},          64'h0022);
        check("t2_issue_count", {32'd0, issue_count}, 64'd2);
        check("t2_gap_count",   64'(gap_q.size()),    64'd1);
        if (gap_q.size() > 0) check("t2_busy_gap", 64'(gap_q[0]), 64'd9);
        repeat (8) @(negedge clk);

        // 3: pc wraps from 0xFFFF to 0x0000
        mem[16'hFFFF] = 15'h0001;
        mem[16'h0000] = 15'h0000;
        busy_len = 0;
        exp_addr_q  = '{16'hFFFF, 16'h0000};
        exp_instr_q = '{15'h0001};
        do_start(16'hFFFF);
        wait_halt(100);
        check("t3_pc",          {48'd0, pc},          64'h0000);
        check("t3_issue_count", {32'd0, issue_count}, 64'd1);
        check("t3_instruction", {49'd0, instruction}, 64'h0001);

        // 4: stop pulsed while the core is busy
        mem[16'h0030] = 15'h0011;
        mem[16'h0031] = 15'h0022;
        mem[16'h0032] = 15'h0033;
        mem[16'h0033] = 15'h0000;
        busy_len = 5;
        exp_addr_q  = '{16'h0030};
        exp_instr_q = '{15'h0011};
        do_start(16'h0030);
        wait_cpen(50);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4_running_while_busy", {63'd0, running}, 64'd1);
        repeat (20) @(negedge clk);
        check("t4_running",     {63'd0, running},     64'd0);
        check("t4_halted",      {63'd0, halted},      64'd0);
        check("t4_issue_count", {32'd0, issue_count}, 64'd1);
        check("t4_pc",          {48'd0, pc},          64'h0031);
        check("t4_fetch_left",  64'(exp_addr_q.size()), 64'd0);

        // 5: reset during WAIT_BUSY, then restart
        mem[16'h0040] = 15'h0055;
        mem[16'h0041] = 15'h0066;
        mem[16'h0042] = 15'h0000;
        exp_addr_q  = '{16'h0040};
        exp_instr_q = '{15'h0055};
        do_start(16'h0040);
        wait_cpen(50);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        exp_addr_q  = '{16'h0040, 16'h0041, 16'h0042};
        exp_instr_q = '{15'h0055, 15'h0066};
        do_start(16'h0040);
        wait_halt(200);
        check("t5_pc",          {48'd0, pc},          64'h0042);
        check("t5_issue_count", {32'd0, issue_count}, 64'd2);
        repeat (8) @(negedge clk);

`ifdef INSTR_ISSUER_STEP_EN
        // 6: single-step gating
        mem[16'h0050] = 15'h0101;
        mem[16'h0051] = 15'h0202;
        mem[16'h0052] = 15'h0303;
        mem[16'h0053] = 15'h0000;
        busy_len = 0;
        step = 1'b0;
        exp_addr_q  = '{16'h0050};
        exp_instr_q = '{15'h0101};
        do_start(16'h0050);
        wait_cpen(50);
        repeat (20) @(negedge clk);
        check("t6_count_held", {32'd0, issue_count}, 64'd1);
        check("t6_pc_held",    {48'd0, pc},          64'h0051);
        check("t6_running",    {63'd0, running},     64'd1);
        exp_addr_q.push_back(16'h0051);
        exp_instr_q.push_back(15'h0202);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_count_step", {32'd0, issue_count}, 64'd2);
        check("t6_pc_step",    {48'd0, pc},          64'h0052);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_stop_idle",  {63'd0, running},     64'd0);
`endif

        check("instr_left", 64'(exp_instr_q.size()), 64'd0);
        check("addr_left",  64'(exp_addr_q.size()),  64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
